// File: rtl/shifter.sv
// Registered 16-bit barrel shifter: logical left shift, arithmetic right
// shift, rotate right or pass-through by 0-15 positions, one-cycle latency.
module shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Shift_In,
  input  logic [3:0]  Shift_Val,
  input  logic [1:0]  Mode,
  output logic [15:0] Shift_Out
);

  typedef enum logic [1:0] {
    MODE_SLL  = 2'd0,
    MODE_SRA  = 2'd1,
    MODE_ROR  = 2'd2,
    MODE_PASS = 2'd3
  } mode_e;

  mode_e       mode;
  logic [15:0] result;

  assign mode = mode_e'(Mode);

  // Log barrel: stage i moves the word by 2**i positions when Shift_Val[i]
  // is set, so the four stages compose to any amount 0-15.
  always_comb begin
    logic [15:0] stage;
    int unsigned amt;
    stage = Shift_In;
    amt   = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      amt = 32'd1 << i;
      if (Shift_Val[i]) begin
        unique case (mode)
          MODE_SLL: stage = stage << amt;
          MODE_SRA: stage = 16'($signed(stage) >>> amt);
          MODE_ROR: stage = (stage >> amt) | (stage << (32'd16 - amt));
          default:  stage = stage;
        endcase
      end
    end
    result = stage;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Shift_Out <= '0;
    end else begin
      Shift_Out <= result;
    end
  end

endmodule

// File: tb/tb_shifter.sv
// Scoreboard bench for shifter: driver pushes expected results from a
// arithmetic reference model, monitor pops and compares one edge later.
module tb_shifter;

  logic        clk;
  logic        rst_n;
  logic [15:0] Shift_In;
  logic [3:0]  Shift_Val;
  logic [1:0]  Mode;
  logic [15:0] Shift_Out;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } sb_item_t;

  sb_item_t q[$];
  int n_cmp;
  int n_err;

  shifter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Shift_In (Shift_In),
    .Shift_Val(Shift_Val),
    .Mode     (Mode),
    .Shift_Out(Shift_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: SLL as multiply mod 2^16, SRA as floor division of the
  // signed value, ROR as a bit-index permutation.
  function automatic logic [15:0] model(input logic [15:0] x, input int k, input int m);
    int          p;
    int          s;
    int          qv;
    int unsigned v;
    logic [15:0] r;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 2;
    r = x;
    case (m)
      0: begin
        v = x;
        v = (v * p) % 65536;
        r = v[15:0];
      end
      1: begin
        s = x[15] ? int'(x) - 65536 : int'(x);
        if (s >= 0) qv = s / p;
        else        qv = -((-s + p - 1) / p);
        r = qv[15:0];
      end
      2: begin
        for (int j = 0; j < 16; j++) r[j] = x[(j + k) % 16];
      end
      default: r = x;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic issue_exp(input logic [15:0] x, input logic [3:0] k,
                           input logic [1:0] m, input logic [15:0] exp, input string name);
    sb_item_t it;
    @(negedge clk);
    Shift_In  = x;
    Shift_Val = k;
    Mode      = m;
    it.exp    = exp;
    it.name   = name;
    q.push_back(it);
  endtask

  task automatic issue(input logic [15:0] x, input logic [3:0] k,
                       input logic [1:0] m, input string name);
    issue_exp(x, k, m, model(x, int'(k), int'(m)), name);
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: the result for inputs presented before an edge is visible
  // just after it.
  always begin
    sb_item_t it;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      it = q.pop_front();
      check(it.name, Shift_Out, it.exp);
    end
  end

  logic [15:0] held;
  logic [15:0] base;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    Shift_In  = 16'hA5C3;
    Shift_Val = 4'd7;
    Mode      = 2'd1;

    #2;
    check("reset_no_clock", Shift_Out, 16'h0000);
    @(posedge clk);
    #2;
    check("reset_held_over_edge", Shift_Out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    issue_exp(16'h1234, 4'd9, 2'd3, 16'h1234, "first_after_reset");
    issue_exp(16'h3333, 4'd4, 2'd0, 16'h3330, "sll_4");
    issue_exp(16'h3333, 4'd15, 2'd0, 16'h8000, "sll_15");
    issue_exp(16'h3333, 4'd1, 2'd1, 16'h1999, "sra_3333_1");
    issue_exp(16'h8000, 4'd3, 2'd1, 16'hF000, "sra_8000_3");
    issue_exp(16'h8000, 4'd15, 2'd1, 16'hFFFF, "sra_8000_15");
    issue_exp(16'h3333, 4'd5, 2'd2, 16'h9999, "ror_3333_5");
    issue_exp(16'h0001, 4'd1, 2'd2, 16'h8000, "ror_0001_1");
    issue_exp(16'hBEEF, 4'd0, 2'd0, 16'hBEEF, "sll_zero");
    issue_exp(16'hBEEF, 4'd0, 2'd1, 16'hBEEF, "sra_zero");
    issue_exp(16'hBEEF, 4'd0, 2'd2, 16'hBEEF, "ror_zero");
    issue_exp(16'hC001, 4'd12, 2'd3, 16'hC001, "pass_mode3");

    // Sweeps over k for 100 consecutive operands per mode.
    base = 16'($urandom);
    for (int m = 0; m < 3; m++) begin
      for (int n = 0; n < 100; n++) begin
        for (int k = 0; k < 16; k++) begin
          case (m)
            0:       issue(16'(base + n), 4'(k), 2'(m), "sll_sweep");
            1:       issue(16'(base + n + 16'h8000 * (n % 2)), 4'(k), 2'(m), "sra_sweep");
            default: issue(16'(base + n), 4'(k), 2'(m), "ror_sweep");
          endcase
        end
      end
    end

    // Back-to-back random ops, mode and amount changing every cycle.
    for (int n = 0; n < 300; n++)
      issue(16'($urandom), 4'($urandom_range(15)), 2'($urandom_range(3)), "random_b2b");
    drain();

    // Mid-cycle input change must not disturb the registered output.
    issue(16'h5A5A, 4'd3, 2'd2, "pre_hold");
    @(posedge clk);
    #3;
    held      = Shift_Out;
    Shift_In  = 16'h0F0F;
    Shift_Val = 4'd6;
    Mode      = 2'd0;
    #3;
    check("hold_mid_cycle", Shift_Out, model(16'h5A5A, 3, 2));
    check("hold_unchanged", Shift_Out, held);

    // Asynchronous reset between edges, mid-stream.
    for (int n = 0; n < 5; n++)
      issue(16'($urandom), 4'($urandom_range(15)), 2'($urandom_range(3)), "pre_reset");
    @(posedge clk);
    #2;
    Shift_In = 16'hFFFF;
    Mode     = 2'd3;
    rst_n    = 1'b0;
    #1;
    check("async_reset_mid", Shift_Out, 16'h0000);
    @(posedge clk);
    #2;
    check("reset_low_stays_zero", Shift_Out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    issue_exp(16'h00F0, 4'd4, 2'd0, 16'h0F00, "resume_after_reset");
    for (int n = 0; n < 20; n++)
      issue(16'($urandom), 4'($urandom_range(15)), 2'($urandom_range(3)), "resume_random");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shifter.md
# shifter

Registered 16-bit barrel shifter for the datapath's ALU shift/rotate instructions. It supports logical left shift, arithmetic right shift and rotate right by 0–15 bit positions, selected by a 2-bit mode. The result is captured in an output register one clock after the operands are presented, and the output register clears on an asynchronous active-low reset.

## Interface
- No parameters. Data width is fixed at 16 bits and shift amount at 4 bits.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst_n  input  1  asynchronous active-low reset; clears the output register.
- Shift_In  input  16  operand to be shifted or rotated.
- Shift_Val  input  4  shift/rotate amount, unsigned 0–15.
- Mode  input  2  operation select: 0 = SLL, 1 = SRA, 2 = ROR, 3 = pass-through.
- Shift_Out  output  16  registered result.

## Operation
- Combinational result R is computed from Shift_In, Shift_Val and Mode.
- Mode 0 (SLL): R = Shift_In << Shift_Val. Vacated low bits are filled with 0. Bits shifted past bit 15 are discarded.
- Mode 1 (SRA): R = signed Shift_In >>> Shift_Val. Vacated high bits are filled with Shift_In[15].
- Mode 2 (ROR): R[15-k:0] = Shift_In[15:k] and R[15:16-k] = Shift_In[k-1:0], where k = Shift_Val.
  - Bits rotated out of the LSB re-enter at the MSB.
  - For k = 0, R = Shift_In.
- Mode 3: R = Shift_In unchanged. This is a decided requirement, not don't-care.
- Shift_Val = 0 yields R = Shift_In in every mode.
- Structure is a 4-stage log barrel: stages 1, 2, 4 and 8, each gated by the corresponding Shift_Val bit.
  - Each stage muxes left-shift, arithmetic-right and rotate-right fill according to Mode.
  - No overflow or carry output.
- Shift_Out register: on each rising clk with rst_n high, Shift_Out <= R.

## Timing
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on Shift_Out after edge N.
- Throughput: one new operation per cycle. There is no handshake and no stall.
- Shift_Out holds its value between edges regardless of input changes.
- Reset:
  - rst_n low forces Shift_Out = 16'h0000 immediately, without waiting for clk.
  - Shift_Out stays 0 while rst_n is low.
  - The first edge after rst_n rises loads R.
- Reset asserted mid-stream: the in-flight result is lost and the output reads 0.
- Inputs must be stable meeting setup/hold around the rising clk edge. The combinational path is four mux levels.

## Test plan
- Reset: rst_n = 0 with arbitrary inputs -> Shift_Out = 0x0000 without a clock edge. Release, apply Shift_In = 0x1234, Mode = 3 -> Shift_Out = 0x1234 after one edge.
- SLL sweep: Shift_In = 0x3333, Mode = 0, Shift_Val 0..15 -> Shift_Out = 0x3333 << k (e.g. k = 4 -> 0x3330, k = 15 -> 0x8000). Repeat for 100 consecutive Shift_In values.
- SRA:
  - 0x3333 >>> 1 -> 0x1999.
  - 0x8000 >>> 3 -> 0xF000.
  - 0x8000 >>> 15 -> 0xFFFF.
  - Full sweep over k for 100 Shift_In values, checked against a signed reference.
- ROR: Shift_In = 0x3333, Mode = 2, Shift_Val = 5 -> 0x9999, i.e. Shift_Out[10:0] = Shift_In[15:5] and Shift_Out[15:11] = Shift_In[4:0]. Also 0x0001 ror 1 -> 0x8000.
- Latency/back-to-back: change Mode/Shift_Val every cycle -> each result appears exactly one edge later with no bubbles. Change inputs mid-cycle -> Shift_Out is unchanged until the next edge.
- Async reset mid-stream: assert rst_n between edges -> Shift_Out goes to 0x0000 immediately. After release, normal results resume on the next edge.
